// File: rtl/load_store_unit.sv
// Load/store unit: word-aligned memory port with byte enables, variable-latency
// handshake with timeout, and a one-cycle response carrying extended data or a fault.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  localparam logic [8:0] TMO = 9'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]  rsp_fault_q, rsp_fault_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;

  logic        illegal, misaligned;
  logic [3:0]  be;
  logic [31:0] lane, load_data;
  logic [8:0]  cnt_inc;

  always_comb begin
    illegal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: illegal = 1'b0;
      3'b100, 3'b101:         illegal = req_we;
      default:                illegal = 1'b1;
    endcase
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    case (req_funct3[1:0])
      2'b00:   be = 4'b0001 << req_addr[1:0];
      2'b01:   be = 4'b0011 << req_addr[1:0];
      default: be = 4'b1111;
    endcase
  end

  always_comb begin
    lane = mem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
      3'b100:  load_data = {24'h0, lane[7:0]};
      3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
      3'b101:  load_data = {16'h0, lane[15:0]};
      default: load_data = lane;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_fault_d = '0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    cnt_d       = cnt_q;
    f3_d        = f3_q;
    off_d       = off_q;
    cnt_inc     = {1'b0, cnt_q} + 9'd1;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          f3_d  = req_funct3;
          off_d = req_addr[1:0];
          cnt_d = '0;
          if (illegal) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_fault_d = 2'b11;
          end else if (misaligned) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_fault_d = 2'b01;
          end else begin
            state_d     = WAIT;
            mem_req_d   = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            // Loads drive no byte enables and no write data.
            mem_be_d    = req_we ? be : 4'b0000;
            mem_wdata_d = req_we ? (req_wdata << {req_addr[1:0], 3'b000}) : '0;
          end
        end
      end
      WAIT: begin
        if (mem_ack) begin
          state_d     = RESP;
          mem_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = mem_we_q ? '0 : load_data;
        end else begin
          cnt_d = cnt_inc[7:0];
          if (cnt_inc >= TMO) begin
            state_d     = RESP;
            mem_req_d   = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_fault_d = 2'b10;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_fault_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      cnt_q       <= '0;
      f3_q        <= '0;
      off_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_fault_q <= rsp_fault_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      cnt_q       <= cnt_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_fault = rsp_fault_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 4-cycle memory timeout.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_fault;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request; ack_at is the cycle after acceptance carrying mem_ack (0 = never).
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input int ack_at, input logic [31:0] rdata,
                        input logic [31:0] exp_rdata, input logic [1:0] exp_fault,
                        input int exp_lat, input int exp_mreq,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    int lat;
    int mreq;
    @(negedge clock);
    check("ready_before", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(negedge clock);
    req_valid = 1'b0;
    lat  = 1;
    mreq = 0;
    while (!rsp_valid && lat < 40) begin
      if (mem_req) mreq++;
      if (lat == 1 && exp_mreq > 0) begin
        check("mem_we",    {31'b0, mem_we}, {31'b0, we});
        check("mem_addr",  mem_addr, {addr[31:2], 2'b00});
        check("mem_be",    {28'b0, mem_be}, {28'b0, exp_be});
        check("mem_wdata", mem_wdata, exp_wdata);
      end
      mem_ack   = (lat == ack_at);
      mem_rdata = rdata;
      @(negedge clock);
      lat++;
    end
    mem_ack = 1'b0;
    if (mem_req) mreq++;
    check("latency",   lat, exp_lat);
    check("mreq_cyc",  mreq, exp_mreq);
    check("rsp_rdata", rsp_rdata, exp_rdata);
    check("rsp_fault", {30'b0, rsp_fault}, {30'b0, exp_fault});
    check("ready_rsp", {31'b0, req_ready}, 32'd0);
    @(negedge clock);
    check("rsp_drop",  {31'b0, rsp_valid}, 32'd0);
    check("rdata_clr", rsp_rdata, 32'd0);
    check("fault_clr", {30'b0, rsp_fault}, 32'd0);
    check("ready_aft", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clock);
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_rspv",  {31'b0, rsp_valid}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_fault", {30'b0, rsp_fault}, 32'd0);
    check("rst_mreq",  {31'b0, mem_req}, 32'd0);
    check("rst_addr",  mem_addr, 32'd0);
    check("rst_be",    {28'b0, mem_be}, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    reset_n = 1'b1;

    // LB / LBU with ack on the second mem_req cycle
    access(1'b0, 3'b000, 32'h103, 32'h0, 2, 32'h80FF7F01, 32'hFFFFFF80, 2'b00, 3, 2, 4'b0000, 32'h0);
    access(1'b0, 3'b100, 32'h103, 32'h0, 1, 32'h80FF7F01, 32'h00000080, 2'b00, 2, 1, 4'b0000, 32'h0);
    // LHU / LH, immediate ack
    access(1'b0, 3'b101, 32'h22, 32'h0, 1, 32'hBEEF1234, 32'h0000BEEF, 2'b00, 2, 1, 4'b0000, 32'h0);
    access(1'b0, 3'b001, 32'h22, 32'h0, 1, 32'hBEEF1234, 32'hFFFFBEEF, 2'b00, 2, 1, 4'b0000, 32'h0);
    // SB / SH / SW
    access(1'b1, 3'b000, 32'h41, 32'hAB, 1, 32'hFFFFFFFF, 32'h0, 2'b00, 2, 1, 4'b0010, 32'h0000AB00);
    access(1'b1, 3'b001, 32'h42, 32'h1234, 1, 32'hFFFFFFFF, 32'h0, 2'b00, 2, 1, 4'b1100, 32'h12340000);
    access(1'b1, 3'b010, 32'h84, 32'hDEADBEEF, 3, 32'h0, 32'h0, 2'b00, 4, 3, 4'b1111, 32'hDEADBEEF);
    // Faults: misaligned LW, illegal SW funct3, misaligned LH
    access(1'b0, 3'b010, 32'h06, 32'h0, 1, 32'h0, 32'h0, 2'b01, 1, 0, 4'b0000, 32'h0);
    access(1'b1, 3'b100, 32'h00, 32'h0, 1, 32'h0, 32'h0, 2'b11, 1, 0, 4'b0000, 32'h0);
    access(1'b0, 3'b001, 32'h13, 32'h0, 1, 32'h0, 32'h0, 2'b01, 1, 0, 4'b0000, 32'h0);
    access(1'b0, 3'b011, 32'h00, 32'h0, 1, 32'h0, 32'h0, 2'b11, 1, 0, 4'b0000, 32'h0);
    // Timeout after 4 mem_req cycles, then ack on the limit cycle wins
    access(1'b0, 3'b010, 32'h10, 32'h0, 0, 32'h0, 32'h0, 2'b10, 5, 4, 4'b0000, 32'h0);
    mem_ack = 1'b1;
    @(negedge clock);
    mem_ack = 1'b0;
    check("stray_rspv",  {31'b0, rsp_valid}, 32'd0);
    check("stray_ready", {31'b0, req_ready}, 32'd1);
    check("stray_mreq",  {31'b0, mem_req}, 32'd0);
    access(1'b0, 3'b010, 32'h10, 32'h0, 4, 32'h11223344, 32'h11223344, 2'b00, 5, 4, 4'b0000, 32'h0);

    // Reset while waiting on memory
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0;
    @(negedge clock);
    req_valid = 1'b0;
    check("wait_mreq", {31'b0, mem_req}, 32'd1);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    check("rstw_mreq",  {31'b0, mem_req}, 32'd0);
    check("rstw_ready", {31'b0, req_ready}, 32'd1);
    check("rstw_rspv",  {31'b0, rsp_valid}, 32'd0);
    mem_ack = 1'b1;
    @(negedge clock);
    mem_ack = 1'b0;
    check("rstw_late",  {31'b0, rsp_valid}, 32'd0);
    access(1'b0, 3'b010, 32'h0, 32'h0, 1, 32'hCAFEF00D, 32'hCAFEF00D, 2'b00, 2, 1, 4'b0000, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
